// File: rtl/mem_port_pkg.sv
// Shared types for the memory-port sequencer: FSM states, write phases and default sizes.
package mem_port_pkg;

   localparam int unsigned DefAddrW = 10;
   localparam int unsigned DefDataW = 12;
   localparam int unsigned DefDepth = 1024;

   typedef enum logic [3:0] {
      StClrAl,
      StClrDl,
      StClrAu,
      StClrDu,
      StHold,
      StWrAl,
      StWrDl,
      StWrAu,
      StWrDu,
      StRun
   } state_e;

   typedef enum logic [1:0] {
      PhAl,
      PhDl,
      PhAu,
      PhDu
   } phase_e;

   // Clear and write states share one phase sequence; idle states map to PhAl.
   function automatic phase_e state_phase(state_e st);
      unique case (st)
         StClrDl, StWrDl: return PhDl;
         StClrAu, StWrAu: return PhAu;
         StClrDu, StWrDu: return PhDu;
         default:         return PhAl;
      endcase
   endfunction

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Loader, CPU and memory-side signals of the multiplexed memory port.
interface mem_port_sequencer_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 12
);

   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              cpu_release;
   logic [ADDR_W-1:0] cpu_addr_data;
   logic              cpu_read_write;
   logic              cpu_write_commit;
   logic [ADDR_W-1:0] mem_addr_data;
   logic              mem_read_write;
   logic              mem_write_commit;

   modport master (
      output ld_valid, ld_addr, ld_data, cpu_release,
      output cpu_addr_data, cpu_read_write, cpu_write_commit,
      input  ld_ready, mem_addr_data, mem_read_write, mem_write_commit
   );

   modport slave (
      input  ld_valid, ld_addr, ld_data, cpu_release,
      input  cpu_addr_data, cpu_read_write, cpu_write_commit,
      output ld_ready, mem_addr_data, mem_read_write, mem_write_commit
   );

endinterface

// File: rtl/mem_phase_mux.sv
// Drives one phase of the four-phase word write from an address/data operand pair.
module mem_phase_mux
   import mem_port_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW
) (
   input  logic              active_i,
   input  phase_e            phase_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [ADDR_W-1:0] addr_data_o,
   output logic              read_write_o,
   output logic              write_commit_o
);

   localparam int unsigned HalfW = DATA_W / 2;

   always_comb begin
      addr_data_o    = '0;
      read_write_o   = 1'b0;
      write_commit_o = 1'b0;
      if (active_i) begin
         read_write_o   = 1'b1;
         write_commit_o = 1'b1;
         unique case (phase_i)
            PhAl, PhAu: addr_data_o = addr_i;
            PhDl:       addr_data_o = ADDR_W'(data_i[HalfW-1:0]);
            PhDu:       addr_data_o = ADDR_W'(data_i[HalfW +: HalfW]);
            default:    addr_data_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_sequencer.sv
// Owns the multiplexed memory port: zero-fill after reset, UART loader writes, then CPU hand-off.
module mem_port_sequencer
   import mem_port_pkg::*;
#(
   parameter int unsigned ADDR_W   = DefAddrW,
   parameter int unsigned DATA_W   = DefDataW,
   parameter int unsigned DEPTH    = DefDepth,
   parameter bit          CLEAR_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_port_sequencer_if.slave  port_io,
   output logic                 cpu_rst_o,
   output logic                 busy_o,
   output logic [7:0]           frames_done_o
);

   localparam state_e            StReset  = CLEAR_EN ? StClrAl : StHold;
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [7:0]        frames_q, frames_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0] buf_data_q, buf_data_d;
   logic              rel_pend_q, rel_pend_d;

   logic              is_clr, is_wr, is_idle, ld_ready, accept;
   logic [ADDR_W-1:0] mux_addr_data;
   logic              mux_read_write, mux_write_commit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StReset;
         clr_addr_q <= '0;
         frames_q   <= '0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         rel_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         frames_q   <= frames_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         rel_pend_q <= rel_pend_d;
      end
   end

   always_comb begin
      is_clr  = (state_q inside {StClrAl, StClrDl, StClrAu, StClrDu});
      is_wr   = (state_q inside {StWrAl, StWrDl, StWrAu, StWrDu});
      is_idle = (state_q == StHold) || (state_q == StRun);
      // Gate with rst_n so the port reads idle while reset is held in any start state.
      ld_ready = rst_n && is_idle;
      accept   = port_io.ld_valid && ld_ready;
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      frames_d   = frames_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      rel_pend_d = rel_pend_q;

      unique case (state_q)
         StClrAl: state_d = StClrDl;
         StClrDl: state_d = StClrAu;
         StClrAu: state_d = StClrDu;
         StClrDu: begin
            if (clr_addr_q == LastAddr) begin
               state_d = StHold;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
               state_d    = StClrAl;
            end
         end
         StHold: begin
            if (accept) begin
               buf_addr_d = port_io.ld_addr;
               buf_data_d = port_io.ld_data;
               state_d    = StWrAl;
               // Frame wins a tie; the release waits until the write completes.
               if (port_io.cpu_release) rel_pend_d = 1'b1;
            end else if (port_io.cpu_release || rel_pend_q) begin
               rel_pend_d = 1'b0;
               state_d    = StRun;
            end
         end
         StWrAl: state_d = StWrDl;
         StWrDl: state_d = StWrAu;
         StWrAu: state_d = StWrDu;
         StWrDu: begin
            frames_d = frames_q + 8'd1;
            if (rel_pend_q || port_io.cpu_release) begin
               rel_pend_d = 1'b0;
               state_d    = StRun;
            end else begin
               state_d = StHold;
            end
         end
         StRun: begin
            if (accept) begin
               buf_addr_d = port_io.ld_addr;
               buf_data_d = port_io.ld_data;
               state_d    = StWrAl;
            end
         end
         default: state_d = StReset;
      endcase

      if ((is_clr || (is_wr && state_q != StWrDu)) && port_io.cpu_release) begin
         rel_pend_d = 1'b1;
      end
   end

   mem_phase_mux #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_phase_mux (
      .active_i      (rst_n && (is_clr || is_wr)),
      .phase_i       (state_phase(state_q)),
      .addr_i        (is_wr ? buf_addr_q : clr_addr_q),
      .data_i        (is_wr ? buf_data_q : '0),
      .addr_data_o   (mux_addr_data),
      .read_write_o  (mux_read_write),
      .write_commit_o(mux_write_commit)
   );

   always_comb begin
      port_io.ld_ready         = ld_ready;
      port_io.mem_addr_data    = mux_addr_data;
      port_io.mem_read_write   = mux_read_write;
      port_io.mem_write_commit = mux_write_commit;
      if (state_q == StRun) begin
         port_io.mem_addr_data    = port_io.cpu_addr_data;
         port_io.mem_read_write   = port_io.cpu_read_write;
         port_io.mem_write_commit = port_io.cpu_write_commit;
      end
      cpu_rst_o     = (state_q != StRun);
      busy_o        = !is_idle;
      frames_done_o = frames_q;
   end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Owns the single 10-bit multiplexed memory port (addr_data / read_write / write_commit) and decides who drives it: the CPU, or the UART loader.
- After reset it zero-fills memory. It then serialises UART-delivered (address, data) write frames into the four-phase write protocol, holding the CPU in reset while loader traffic is pending.
- It hands the port back to the CPU on a release command.
- It sits between the UART frame parser, the CPU core and the memory block in the FPGA top level.

Parameters:
- ADDR_W, 10, memory address width; also the addr_data bus width.
- DATA_W, 12, memory word width; split into two halves of DATA_W/2.
- DEPTH, 1024, number of words zero-filled after reset.
- CLEAR_EN, 1, 1 = perform the zero-fill after reset; 0 = skip it.

Ports:
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader frame valid.
- ld_ready  out  1  sequencer can accept a frame.
- ld_addr  in  ADDR_W  target word address.
- ld_data  in  DATA_W  word to write.
- cpu_release  in  1  single-cycle pulse: return the port to the CPU once idle.
- cpu_addr_data  in  ADDR_W  CPU port bus.
- cpu_read_write  in  1  CPU read/write.
- cpu_write_commit  in  1  CPU write commit.
- mem_addr_data  out  ADDR_W  bus to memory.
- mem_read_write  out  1  to memory.
- mem_write_commit  out  1  to memory.
- cpu_rst  out  1  active-high reset to the CPU core.
- busy  out  1  sequencer owns the port (any state other than RUN/HOLD).
- frames_done  out  8  count of completed loader frames; wraps at 255 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - state = CLEAR_EN ? CLR_AL : HOLD; clr_addr = 0; frames_done = 0; frame buffer empty.
  - cpu_rst = 1; ld_ready = 0; mem_* outputs = 0.
- Four-phase write: a word write occupies 4 consecutive cycles, each with mem_read_write = 1 and mem_write_commit = 1.
  - AL: addr_data = address.
  - DL: addr_data = zero-extended data[DATA_W/2-1:0].
  - AU: addr_data = address.
  - DU: addr_data = zero-extended data[DATA_W-1:DATA_W/2].
- mem_* outputs are combinational from state plus registered operands. All other bookkeeping is registered.
- States and transitions:
  - CLR_AL -> CLR_DL -> CLR_AU -> CLR_DU: writes data 0 to clr_addr.
    - In CLR_DU: if clr_addr == DEPTH-1, go to HOLD; else clr_addr += 1 and return to CLR_AL.
    - Fill takes exactly 4*DEPTH cycles.
  - HOLD: port idle (mem_* = 0); cpu_rst = 1; ld_ready = 1.
    - On ld_valid && ld_ready: latch ld_addr/ld_data and go to WR_AL.
    - Else on cpu_release (or a latched pending release): go to RUN.
  - WR_AL -> WR_DL -> WR_AU -> WR_DU: four-phase write of the latched frame.
    - In WR_DU: frames_done += 1. Next state is HOLD, or RUN if a release is pending.
    - ld_ready = 0 throughout.
  - RUN: mem_* = cpu_* (combinational pass-through); cpu_rst = 0; ld_ready = 1.
    - On accepting a frame: cpu_rst asserts the next cycle, state goes to WR_AL, and the CPU restarts from reset after the next release.
- Release handling:
  - cpu_release arriving during CLR_* or WR_* is latched and honoured at the next HOLD exit point.
  - cpu_release in RUN is ignored.
- Simultaneous events:
  - In HOLD, ld_valid and cpu_release in the same cycle: the frame wins; the release stays pending and takes effect after WR_DU.
  - Frames are never dropped: ld_ready is 0 in every CLR_* and WR_* state.
- Reset mid-operation: an asynchronous rst_n abandons any in-flight frame or fill. The fill restarts from address 0 when CLEAR_EN = 1.

Decomposition:
- Shared package mem_port_pkg holds:
  - the state enum (CLR_AL..CLR_DU, HOLD, WR_AL..WR_DU, RUN);
  - the phase encoding;
  - constants for default ADDR_W, DATA_W and DEPTH.
- One sub-module, mem_phase_mux: given phase, address and data, it produces the combinational addr_data / read_write / write_commit. It is shared by the clear and write paths.

Test Plan:
- Reset release with CLEAR_EN=1, DEPTH=1024 -> exactly 4096 busy cycles of AL/DL/AU/DU for addresses 0..1023, all data 0; then HOLD with cpu_rst=1 and ld_ready=1.
- In HOLD, frame addr=0x155, data=0xABC -> mem_addr_data sequence 0x155, 0x03C, 0x155, 0x02A on consecutive cycles with rw=commit=1; frames_done goes 0->1.
- cpu_release pulse in HOLD -> RUN the next cycle, cpu_rst=0, and cpu_addr_data=0x2A7 appears on mem_addr_data in the same cycle.
- cpu_release pulsed during WR_DL of a frame -> write completes, then RUN directly after WR_DU with no intermediate HOLD cycle.
- ld_valid and cpu_release together in HOLD -> frame written first, then RUN; ld_ready low for the 4 write cycles.
- rst_n pulsed low during WR_AU -> outputs go to their reset values immediately; fill restarts at address 0; frames_done = 0; the in-flight frame is not completed.
